// File: rtl/conv_stream_engine.sv
// KxK sliding-window convolution engine: column window, 2-stage multiply/sum pipeline,
// saturate/wrap reduction and a credit-protected result FIFO with valid/ready output.
module conv_stream_engine #(
    parameter int K          = 3,
    parameter int DATA_W     = 4,
    parameter int RES_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          clear,
    input  logic                          coeff_wr,
    input  logic [$clog2(K*K)-1:0]        coeff_idx,
    input  logic [DATA_W-1:0]             coeff_data,
    output logic                          coeff_err,
    input  logic                          col_valid,
    output logic                          col_ready,
    input  logic [K*DATA_W-1:0]           col_data,
    input  logic                          new_row,
    input  logic                          sat_en,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [RES_W-1:0]              res_data,
    output logic [$clog2(FIFO_DEPTH):0]   res_count,
    output logic                          busy
);

    localparam int NC     = K * K;
    localparam int IDX_W  = $clog2(NC);
    localparam int PROD_W = 2 * DATA_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NC);
    localparam int SUM_W  = (ACC_W > RES_W) ? ACC_W : RES_W;
    localparam int FILL_W = $clog2(K + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [K*DATA_W-1:0]      win [K];
    logic [FILL_W-1:0]        fill;
    logic [FILL_W-1:0]        fill_nxt;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s2_sat;
    logic signed [PROD_W-1:0] prod [NC];
    logic [DATA_W-1:0]        coeff [NC];
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  max_v;
    logic signed [SUM_W-1:0]  min_v;
    logic [RES_W-1:0]         reduced;
    logic [RES_W-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [RES_W-1:0]         hold_q;
    logic [CNT_W:0]           credit;
    logic                     accept;
    logic                     coeff_ok;
    logic                     push;
    logic                     pop;

    // Sample is unsigned, coefficient signed; both widened so the product is exact.
    function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_W-1:0] s,
                                                     input logic [DATA_W-1:0] c);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = $signed({{(PROD_W-DATA_W){1'b0}}, s});
        b = $signed({{(PROD_W-DATA_W){c[DATA_W-1]}}, c});
        return a * b;
    endfunction

    // In-flight stages are charged against FIFO space even before the window is full.
    assign credit    = {1'b0, count} + (CNT_W+1)'(s1_valid) + (CNT_W+1)'(s2_valid);
    assign col_ready = credit < (CNT_W+1)'(FIFO_DEPTH);
    assign accept    = col_valid & col_ready;
    assign busy      = s1_valid | s2_valid;
    assign coeff_ok  = coeff_wr & ~busy & ~accept & ({1'b0, coeff_idx} < (IDX_W+1)'(NC));
    assign push      = s2_valid & ~clear;
    assign pop       = (count != '0) & res_ready & ~clear;
    assign res_valid = (count != '0);
    assign res_count = count;
    assign res_data  = (count == '0) ? hold_q : mem[rd_ptr];

    always_comb begin
        fill_nxt = fill;
        if (new_row)
            fill_nxt = FILL_W'(1);
        else if (fill != FILL_W'(K))
            fill_nxt = fill + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int j = 0; j < K; j++) win[j] <= '0;
            fill     <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (accept) begin
                win[0] <= col_data;
                for (int j = 1; j < K; j++) win[j] <= win[j-1];
            end
            s1_valid <= accept & ~clear & (fill_nxt == FILL_W'(K));
            if (clear)
                fill <= '0;
            else if (accept)
                fill <= fill_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NC; i++) prod[i] <= '0;
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
        end else begin
            s2_valid <= s1_valid & ~clear;
            if (s1_valid) begin
                s2_sat <= sat_en;
                for (int r = 0; r < K; r++)
                    for (int j = 0; j < K; j++)
                        prod[r*K+j] <= mul(win[j][r*DATA_W +: DATA_W], coeff[r*K+j]);
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NC; i++)
            acc = acc + {{(SUM_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
        max_v = '0;
        max_v[RES_W-2:0] = '1;
        min_v = '1;
        min_v[RES_W-2:0] = '0;
        if (s2_sat && (acc > max_v))
            reduced = max_v[RES_W-1:0];
        else if (s2_sat && (acc < min_v))
            reduced = min_v[RES_W-1:0];
        else
            reduced = acc[RES_W-1:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NC; i++) coeff[i] <= '0;
            coeff_err <= 1'b0;
        end else begin
            coeff_err <= coeff_wr & ~coeff_ok;
            if (coeff_ok)
                coeff[coeff_idx] <= coeff_data;
        end
    end

    // hold_q tracks the visible output so res_data stays put once the FIFO drains or is cleared.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            hold_q <= res_data;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= reduced;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
